xact_arbiter: RTL and testbench

XACT_ARBITER -- requirements
Module: xact_arbiter

---
 rtl/xact_arbiter_if.sv | 40 ++++
 rtl/xact_arbiter.sv | 172 +++++++++++++++++
 tb/tb_xact_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/xact_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : xact_arbiter_if
// Description : Requester-side and bus-side signal bundle for xact_arbiter.
//               The master modport is the arbiter's view; the slave modport
//               is the view of whatever drives requests and the bus reply.
// Revision    : 1.0 - initial release
// ============================================================================
interface xact_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Requester side: one slot per requester, packed side by side
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_wr_en;
    logic [NUM_REQ*17-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic [31:0]           done_rdata;
    logic                  busy;

    // Bus side
    logic                  sel;
    logic                  en;
    logic [16:0]           addr;
    logic [31:0]           wr_data;
    logic                  wr_en;
    logic [31:0]           rd_data;

    modport master (
        input  req, req_wr_en, req_addr, req_wdata, rd_data,
        output gnt, done, done_rdata, busy, sel, en, addr, wr_data, wr_en
    );

    modport slave (
        output req, req_wr_en, req_addr, req_wdata, rd_data,
        input  gnt, done, done_rdata, busy, sel, en, addr, wr_data, wr_en
    );
endinterface
`default_nettype wire

// File: rtl/xact_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xact_arbiter
// Description : Round-robin arbiter that serialises requester transfers onto
//               a SETUP/ACCESS style bus. One transfer in flight at a time;
//               back-to-back transfers run with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module xact_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  wire            sys_clk,
    input  wire            rst,
    xact_arbiter_if.master bus
);

    localparam int              IDXW      = $clog2(NUM_REQ);
    localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [IDXW-1:0] IDX_MAX   = IDXW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDXW-1:0]      ptr_q;
    logic [IDXW-1:0]      cur_q;
    logic [3:0]           wait_q;
    logic [IDXW-1:0]      win_idx;
    logic                 any_req;
    logic                 last_access;
    logic                 final_access;
    logic                 arb_go;

    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [31:0]          done_rdata_q;
    logic                 busy_q;
    logic                 sel_q;
    logic                 en_q;
    logic [16:0]          addr_q;
    logic [31:0]          wr_data_q;
    logic                 wr_en_q;

    // First requesting index at or after the pointer, wrapping modulo NUM_REQ
    function automatic logic [IDXW-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDXW-1:0]    p
    );
        logic [IDXW-1:0] pick;
        logic [IDXW-1:0] cand;
        logic            found;
        pick  = p;
        cand  = p;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = (cand == IDX_MAX) ? '0 : cand + IDXW'(1);
        end
        return pick;
    endfunction

    // Next-state decode; arbitration happens only when leaving IDLE or the last ACCESS cycle
    always_comb begin
        state_d      = state_q;
        arb_go       = 1'b0;
        any_req      = |bus.req;
        last_access  = (wait_q == WAIT_LAST);
        final_access = (state_q == ST_ACCESS) && last_access;
        win_idx      = rr_pick(bus.req, ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_SETUP;
                    arb_go  = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (last_access) begin
                    if (any_req) begin
                        state_d = ST_SETUP;
                        arb_go  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture, pointer, wait counter and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ptr_q        <= '0;
            cur_q        <= '0;
            wait_q       <= 4'd0;
            gnt_q        <= '0;
            done_q       <= '0;
            done_rdata_q <= 32'h0;
            busy_q       <= 1'b0;
            sel_q        <= 1'b0;
            en_q         <= 1'b0;
            addr_q       <= 17'h0;
            wr_data_q    <= 32'h0;
            wr_en_q      <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;

            // addr/wr_data double as the command register and hold through IDLE
            if (arb_go) begin
                gnt_q     <= NUM_REQ'(1) << win_idx;
                ptr_q     <= (win_idx == IDX_MAX) ? '0 : win_idx + IDXW'(1);
                cur_q     <= win_idx;
                addr_q    <= bus.req_addr[win_idx*17 +: 17];
                wr_data_q <= bus.req_wdata[win_idx*32 +: 32];
                wr_en_q   <= bus.req_wr_en[win_idx];
            end else if (state_d == ST_IDLE) begin
                wr_en_q   <= 1'b0;
            end

            // wr_en_q still reflects the finishing transfer's direction here
            if (final_access) begin
                done_q       <= NUM_REQ'(1) << cur_q;
                done_rdata_q <= wr_en_q ? 32'h0 : bus.rd_data;
            end

            if (arb_go) begin
                wait_q <= 4'd0;
            end else if ((state_q == ST_ACCESS) && !last_access) begin
                wait_q <= wait_q + 4'd1;
            end

            sel_q  <= (state_d != ST_IDLE);
            busy_q <= (state_d != ST_IDLE);
            en_q   <= (state_d == ST_ACCESS);
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.done_rdata = done_rdata_q;
    assign bus.busy       = busy_q;
    assign bus.sel        = sel_q;
    assign bus.en         = en_q;
    assign bus.addr       = addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_en      = wr_en_q;

endmodule
`default_nettype wire

// File: tb/tb_xact_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xact_arbiter
// Description : Directed self-checking bench for xact_arbiter. Three copies
//               with WAIT_CYCLES = 0, 3 and 2 share one clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xact_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic rst_c;
    int   n_cmp  = 0;
    int   n_fail = 0;

    xact_arbiter_if #(.NUM_REQ(4)) ifa ();
    xact_arbiter_if #(.NUM_REQ(4)) ifb ();
    xact_arbiter_if #(.NUM_REQ(4)) ifc ();

    xact_arbiter #(.NUM_REQ(4), .WAIT_CYCLES(0)) dut_a (.sys_clk(clk), .rst(rst_a), .bus(ifa));
    xact_arbiter #(.NUM_REQ(4), .WAIT_CYCLES(3)) dut_b (.sys_clk(clk), .rst(rst_b), .bus(ifb));
    xact_arbiter #(.NUM_REQ(4), .WAIT_CYCLES(2)) dut_c (.sys_clk(clk), .rst(rst_c), .bus(ifc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_chk(input string tag,
                           input logic [3:0] og, input logic [3:0] od,
                           input logic os, input logic oe,
                           input logic [3:0] eg, input logic [3:0] ed,
                           input logic es, input logic ee);
        chk({tag, ".gnt"},  64'(og), 64'(eg));
        chk({tag, ".done"}, 64'(od), 64'(ed));
        chk({tag, ".sel"},  64'(os), 64'(es));
        chk({tag, ".en"},   64'(oe), 64'(ee));
    endtask

    initial begin
        logic [3:0] eg;
        logic [3:0] ed;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.req = 4'b1111; ifa.req_wr_en = 4'b1111; ifa.req_addr = '0; ifa.req_wdata = '0; ifa.rd_data = 32'h0;
        ifb.req = 4'b0000; ifb.req_wr_en = 4'b0000; ifb.req_addr = '0; ifb.req_wdata = '0; ifb.rd_data = 32'h0;
        ifc.req = 4'b0000; ifc.req_wr_en = 4'b0000; ifc.req_addr = '0; ifc.req_wdata = '0; ifc.rd_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ifa.req_addr[i*17 +: 17]  = 17'h100 + 17'(i);
            ifa.req_wdata[i*32 +: 32] = 32'hA0 + 32'(i);
        end
        tick();
        tick();

        // Reset state, with A's requests ignored while reset is held
        bus_chk("rst_a", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0, 1'b0, 1'b0);
        chk("rst_a.wr_en",      64'(ifa.wr_en),      64'(0));
        chk("rst_a.addr",       64'(ifa.addr),       64'(0));
        chk("rst_a.wr_data",    64'(ifa.wr_data),    64'(0));
        chk("rst_a.done_rdata", 64'(ifa.done_rdata), 64'(0));
        chk("rst_a.busy",       64'(ifa.busy),       64'(0));
        bus_chk("rst_b", ifb.gnt, ifb.done, ifb.sel, ifb.en, 4'b0, 4'b0, 1'b0, 1'b0);
        bus_chk("rst_c", ifc.gnt, ifc.done, ifc.sel, ifc.en, 4'b0, 4'b0, 1'b0, 1'b0);

        ifa.req = 4'b0000; ifa.req_wr_en = 4'b0000;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();
        bus_chk("idle_a", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0, 1'b0, 1'b0);

        // Single read, WAIT_CYCLES=0
        ifa.req_addr[2*17 +: 17] = 17'h1ABCD;
        ifa.req = 4'b0100;
        tick();
        bus_chk("t22.setup", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0100, 4'b0, 1'b1, 1'b0);
        chk("t22.addr",  64'(ifa.addr),  64'(17'h1ABCD));
        chk("t22.wr_en", 64'(ifa.wr_en), 64'(0));
        chk("t22.busy",  64'(ifa.busy),  64'(1));
        ifa.req = 4'b0000;
        ifa.rd_data = 32'hDEADBEEF;
        tick();
        bus_chk("t22.access", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0, 1'b1, 1'b1);
        tick();
        bus_chk("t22.done", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0100, 1'b0, 1'b0);
        chk("t22.rdata",     64'(ifa.done_rdata), 64'(32'hDEADBEEF));
        chk("t22.busy_idle", 64'(ifa.busy),       64'(0));
        chk("t22.addr_hold", 64'(ifa.addr),       64'(17'h1ABCD));
        ifa.rd_data = 32'h0;
        tick();
        chk("t22.done_low",   64'(ifa.done),       64'(0));
        chk("t22.rdata_hold", 64'(ifa.done_rdata), 64'(32'hDEADBEEF));

        // Write with WAIT_CYCLES=3
        ifb.req_wr_en = 4'b0001;
        ifb.req_addr[16:0] = 17'h00042;
        ifb.req_wdata[31:0] = 32'h12345678;
        ifb.rd_data = 32'hFFFFFFFF;
        ifb.req = 4'b0001;
        tick();
        bus_chk("t23.setup", ifb.gnt, ifb.done, ifb.sel, ifb.en, 4'b0001, 4'b0, 1'b1, 1'b0);
        chk("t23.wr_en",   64'(ifb.wr_en),   64'(1));
        chk("t23.wr_data", 64'(ifb.wr_data), 64'(32'h12345678));
        ifb.req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            bus_chk("t23.access", ifb.gnt, ifb.done, ifb.sel, ifb.en, 4'b0, 4'b0, 1'b1, 1'b1);
            chk("t23.wr_en_acc", 64'(ifb.wr_en), 64'(1));
        end
        tick();
        bus_chk("t23.done", ifb.gnt, ifb.done, ifb.sel, ifb.en, 4'b0, 4'b0001, 1'b0, 1'b0);
        chk("t23.rdata", 64'(ifb.done_rdata), 64'(0));
        chk("t23.wr_en_idle", 64'(ifb.wr_en), 64'(0));

        // All four requesting continuously from reset
        rst_a = 1'b1;
        ifa.req_addr[2*17 +: 17] = 17'h102;
        ifa.req = 4'b1111;
        tick();
        bus_chk("t24.rst", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0, 1'b0, 1'b0);
        rst_a = 1'b0;
        tick();
        bus_chk("t24.first", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0001, 4'b0, 1'b1, 1'b0);
        chk("t24.addr0", 64'(ifa.addr), 64'(17'h100));
        for (int n = 1; n <= 4; n++) begin
            tick();
            bus_chk("t24.access", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0, 1'b1, 1'b1);
            tick();
            eg = 4'b0001 << (n % 4);
            ed = 4'b0001 << (n - 1);
            bus_chk("t24.b2b", ifa.gnt, ifa.done, ifa.sel, ifa.en, eg, ed, 1'b1, 1'b0);
            chk("t24.addr", 64'(ifa.addr), 64'(17'h100 + 17'(n % 4)));
        end
        ifa.req = 4'b0000;
        tick();
        tick();
        bus_chk("t24.end", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0001, 1'b0, 1'b0);

        // Pointer is 1: single grant to 1 moves it to 2
        ifa.req = 4'b0010;
        tick();
        bus_chk("t25.pre", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0010, 4'b0, 1'b1, 1'b0);
        ifa.req = 4'b0000;
        tick();
        tick();
        bus_chk("t25.pre_done", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0010, 1'b0, 1'b0);

        // req=1010 with pointer 2: grant 3, then 1
        ifa.req = 4'b1010;
        tick();
        bus_chk("t25.g3", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b1000, 4'b0, 1'b1, 1'b0);
        chk("t25.addr3", 64'(ifa.addr), 64'(17'h103));
        ifa.req = 4'b0010;
        tick();
        tick();
        bus_chk("t25.g1", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0010, 4'b1000, 1'b1, 1'b0);
        chk("t25.addr1", 64'(ifa.addr), 64'(17'h101));
        ifa.req = 4'b0000;
        tick();
        tick();
        bus_chk("t25.done1", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0010, 1'b0, 1'b0);
        ifa.req = 4'b1111;
        tick();
        bus_chk("t25.ptr2", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0100, 4'b0, 1'b1, 1'b0);
        ifa.req = 4'b0000;
        tick();
        tick();
        bus_chk("t25.done2", ifa.gnt, ifa.done, ifa.sel, ifa.en, 4'b0, 4'b0100, 1'b0, 1'b0);

        // Reset during second ACCESS cycle of a WAIT_CYCLES=2 read
        ifc.req_addr[1*17 +: 17] = 17'h0BEEF;
        ifc.rd_data = 32'hCAFEF00D;
        ifc.req = 4'b0010;
        tick();
        bus_chk("t26.setup", ifc.gnt, ifc.done, ifc.sel, ifc.en, 4'b0010, 4'b0, 1'b1, 1'b0);
        tick();
        bus_chk("t26.acc1", ifc.gnt, ifc.done, ifc.sel, ifc.en, 4'b0, 4'b0, 1'b1, 1'b1);
        tick();
        bus_chk("t26.acc2", ifc.gnt, ifc.done, ifc.sel, ifc.en, 4'b0, 4'b0, 1'b1, 1'b1);
        rst_c = 1'b1;
        tick();
        bus_chk("t26.abort", ifc.gnt, ifc.done, ifc.sel, ifc.en, 4'b0, 4'b0, 1'b0, 1'b0);
        chk("t26.busy", 64'(ifc.busy), 64'(0));
        rst_c = 1'b0;
        tick();
        bus_chk("t26.rerun", ifc.gnt, ifc.done, ifc.sel, ifc.en, 4'b0010, 4'b0, 1'b1, 1'b0);
        chk("t26.addr", 64'(ifc.addr), 64'(17'h0BEEF));
        ifc.req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            bus_chk("t26.access", ifc.gnt, ifc.done, ifc.sel, ifc.en, 4'b0, 4'b0, 1'b1, 1'b1);
        end
        tick();
        bus_chk("t26.done", ifc.gnt, ifc.done, ifc.sel, ifc.en, 4'b0, 4'b0010, 1'b0, 1'b0);
        chk("t26.rdata", 64'(ifc.done_rdata), 64'(32'hCAFEF00D));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
